// File: rtl/pwl_pkg.sv
// Shared types and arithmetic for the piecewise-linear waveform generator.
// sat_add is sized to the default PARAM_SIZE; the top uses that width.
package pwl_pkg;

  localparam int unsigned PARAM_SIZE = 32;
  localparam int unsigned POINTS     = 9;
  localparam int unsigned DAC_WIDTH  = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } pwl_state_t;

  // Signed add that clamps to the most positive / most negative word.
  function automatic logic [PARAM_SIZE-1:0] sat_add(input logic [PARAM_SIZE-1:0] a,
                                                    input logic [PARAM_SIZE-1:0] b);
    logic [PARAM_SIZE:0] sum;
    sum = {a[PARAM_SIZE-1], a} + {b[PARAM_SIZE-1], b};
    if (sum[PARAM_SIZE] != sum[PARAM_SIZE-1]) begin
      sat_add = sum[PARAM_SIZE] ? {1'b1, {(PARAM_SIZE-1){1'b0}}}
                                : {1'b0, {(PARAM_SIZE-1){1'b1}}};
    end else begin
      sat_add = sum[PARAM_SIZE-1:0];
    end
  endfunction

endpackage

// File: rtl/pwl_line_cnt.sv
// Sample, line and repeat counters for the waveform replay.
// Advances once per accepted sample and flags end-of-line / end-of-sequence.
module pwl_line_cnt #(
  parameter int unsigned PARAM_SIZE = 32,
  parameter int unsigned POINTS     = 9,
  parameter int unsigned SEG_W      = $clog2(POINTS)
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               load,
  input  logic [PARAM_SIZE-1:0]              load_len,
  input  logic                               adv,
  input  logic [PARAM_SIZE-1:0]              linenmb,
  input  logic [PARAM_SIZE-1:0]              repeatcycle,
  input  logic [POINTS-1:0][PARAM_SIZE-1:0]  linet,
  output logic [SEG_W-1:0]                   seg,
  output logic [SEG_W-1:0]                   next_seg,
  output logic                               end_line,
  output logic                               last_line,
  output logic                               end_seq
);

  logic [PARAM_SIZE-1:0] cnt;
  logic [PARAM_SIZE-1:0] cycle;
  logic [PARAM_SIZE-1:0] next_len;

  assign end_line  = (cnt == PARAM_SIZE'(1));
  assign last_line = (PARAM_SIZE'(seg) == linenmb - PARAM_SIZE'(1));
  assign end_seq   = end_line && last_line && (repeatcycle != '0) &&
                     (cycle == repeatcycle - PARAM_SIZE'(1));
  // After the last line the sequence wraps back to line 0.
  assign next_seg  = last_line ? '0 : seg + 1'b1;
  assign next_len  = linet[next_seg];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      seg   <= '0;
      cycle <= '0;
    end else if (load) begin
      cnt   <= load_len;
      seg   <= '0;
      cycle <= '0;
    end else if (adv) begin
      if (!end_line) begin
        cnt <= cnt - PARAM_SIZE'(1);
      end else if (!end_seq) begin
        seg <= next_seg;
        cnt <= (next_len == '0) ? PARAM_SIZE'(1) : next_len;
        if (last_line) begin
          cycle <= cycle + PARAM_SIZE'(1);
        end
      end
    end
  end

endmodule

// File: rtl/pwl_wave_gen.sv
// Piecewise-linear waveform player: replays a snapshot of line parameters as a
// stream of DAC samples with valid/ready flow control.
module pwl_wave_gen #(
  parameter int unsigned PARAM_SIZE = pwl_pkg::PARAM_SIZE,
  parameter int unsigned POINTS     = pwl_pkg::POINTS,
  parameter int unsigned DAC_WIDTH  = pwl_pkg::DAC_WIDTH
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [PARAM_SIZE-1:0]              params_linenmb,
  input  logic [POINTS-1:0][PARAM_SIZE-1:0]  params_linea,
  input  logic [POINTS-1:0][PARAM_SIZE-1:0]  params_linet,
  input  logic [POINTS-1:0][PARAM_SIZE-1:0]  params_linet_int,
  input  logic [PARAM_SIZE-1:0]              params_repeatcycle,
  input  logic                               start,
  input  logic                               stop,
  output logic [DAC_WIDTH-1:0]               m_tdata,
  output logic                               m_tvalid,
  input  logic                               m_tready,
  output logic                               busy,
  output logic                               done,
  output logic                               cfg_err
);

  import pwl_pkg::*;

  localparam int unsigned SEG_W = $clog2(POINTS);

  pwl_state_t state_q, state_d;
  logic [PARAM_SIZE-1:0] acc_q, acc_d;
  logic                  cfg_err_q, cfg_err_d;

  logic [PARAM_SIZE-1:0]             linenmb_q;
  logic [PARAM_SIZE-1:0]             repeat_q;
  logic [POINTS-1:0][PARAM_SIZE-1:0] linea_q;
  logic [POINTS-1:0][PARAM_SIZE-1:0] linet_q;
  logic [POINTS-1:0][PARAM_SIZE-1:0] linet_int_q;

  logic             load, hs, adv, cfg_bad;
  logic             end_line, last_line, end_seq;
  logic [SEG_W-1:0] seg, next_seg;
  logic [PARAM_SIZE-1:0] load_len;

  assign cfg_bad  = (params_linenmb == '0) || (params_linenmb > PARAM_SIZE'(POINTS));
  assign load_len = (params_linet[0] == '0) ? PARAM_SIZE'(1) : params_linet[0];
  assign hs       = (state_q == RUN) && m_tready;
  assign adv      = hs && !stop;

  pwl_line_cnt #(
    .PARAM_SIZE (PARAM_SIZE),
    .POINTS     (POINTS),
    .SEG_W      (SEG_W)
  ) u_line_cnt (
    .clk         (clk),
    .rst         (rst),
    .load        (load),
    .load_len    (load_len),
    .adv         (adv),
    .linenmb     (linenmb_q),
    .repeatcycle (repeat_q),
    .linet       (linet_q),
    .seg         (seg),
    .next_seg    (next_seg),
    .end_line    (end_line),
    .last_line   (last_line),
    .end_seq     (end_seq)
  );

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    cfg_err_d = 1'b0;
    load      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (cfg_bad) begin
            cfg_err_d = 1'b1;
          end else begin
            load    = 1'b1;
            acc_d   = params_linea[0];
            state_d = RUN;
          end
        end
      end
      RUN: begin
        // stop outranks a handshake in the same cycle.
        if (stop) begin
          state_d = IDLE;
        end else if (hs) begin
          if (end_seq) begin
            state_d = DONE;
          end else if (!end_line) begin
            acc_d = sat_add(acc_q, linet_int_q[seg]);
          end else begin
            acc_d = linea_q[next_seg];
          end
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      cfg_err_q   <= 1'b0;
      linenmb_q   <= '0;
      repeat_q    <= '0;
      linea_q     <= '0;
      linet_q     <= '0;
      linet_int_q <= '0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      cfg_err_q <= cfg_err_d;
      if (load) begin
        linenmb_q   <= params_linenmb;
        repeat_q    <= params_repeatcycle;
        linea_q     <= params_linea;
        linet_q     <= params_linet;
        linet_int_q <= params_linet_int;
      end
    end
  end

  assign m_tdata  = acc_q[PARAM_SIZE-1 -: DAC_WIDTH];
  assign m_tvalid = (state_q == RUN);
  assign busy     = (state_q != IDLE);
  assign done     = (state_q == DONE);
  assign cfg_err  = cfg_err_q;

endmodule

// File: tb/tb_pwl_wave_gen.sv
// Directed bench for pwl_wave_gen: table of playback scenarios plus
// hand-written config-error, stop and asynchronous-reset sequences.
module tb_pwl_wave_gen;

  localparam int PS = 32;
  localparam int NP = 9;
  localparam int DW = 16;

  logic                      clk = 1'b0;
  logic                      rst;
  logic [PS-1:0]             params_linenmb;
  logic [NP-1:0][PS-1:0]     params_linea;
  logic [NP-1:0][PS-1:0]     params_linet;
  logic [NP-1:0][PS-1:0]     params_linet_int;
  logic [PS-1:0]             params_repeatcycle;
  logic                      start, stop;
  logic [DW-1:0]             m_tdata;
  logic                      m_tvalid, m_tready;
  logic                      busy, done, cfg_err;

  pwl_wave_gen #(
    .PARAM_SIZE (PS),
    .POINTS     (NP),
    .DAC_WIDTH  (DW)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .params_linenmb     (params_linenmb),
    .params_linea       (params_linea),
    .params_linet       (params_linet),
    .params_linet_int   (params_linet_int),
    .params_repeatcycle (params_repeatcycle),
    .start              (start),
    .stop               (stop),
    .m_tdata            (m_tdata),
    .m_tvalid           (m_tvalid),
    .m_tready           (m_tready),
    .busy               (busy),
    .done               (done),
    .cfg_err            (cfg_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0]       n;
    logic [31:0]       a0;
    logic [31:0]       a1;
    logic [31:0]       t0;
    logic [31:0]       t1;
    logic [31:0]       i0;
    logic [31:0]       i1;
    logic [31:0]       rep;
    logic              stall;
    logic [7:0]        nexp;
    logic [15:0][15:0] exp;
  } vec_t;

  vec_t vecs[7];
  int   nvec  = 0;
  int   nfail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    nvec++;
    if (act !== req) begin
      nfail++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  function automatic vec_t mk(input logic [31:0] n, a0, a1, t0, t1, i0, i1, rep,
                              input logic stall, input logic [7:0] nexp);
    vec_t v;
    v.n = n; v.a0 = a0; v.a1 = a1; v.t0 = t0; v.t1 = t1;
    v.i0 = i0; v.i1 = i1; v.rep = rep; v.stall = stall; v.nexp = nexp;
    v.exp = '0;
    return v;
  endfunction

  task automatic apply_params(input vec_t v);
    params_linenmb      = v.n;
    params_linea        = '0;
    params_linet        = '0;
    params_linet_int    = '0;
    params_linea[0]     = v.a0;
    params_linea[1]     = v.a1;
    params_linet[0]     = v.t0;
    params_linet[1]     = v.t1;
    params_linet_int[0] = v.i0;
    params_linet_int[1] = v.i1;
    params_repeatcycle  = v.rep;
  endtask

  task automatic run_vec(input vec_t v, input string name);
    int            k;
    bit            seen_done;
    bit            stalled;
    logic [15:0]   held;
    apply_params(v);
    @(negedge clk);
    start    = 1'b1;
    m_tready = 1'b1;
    @(negedge clk);
    start     = 1'b0;
    k         = 0;
    seen_done = 1'b0;
    stalled   = 1'b0;
    held      = '0;
    for (int c = 0; c < 200 && !seen_done; c++) begin
      if (c > 0) @(negedge clk);
      if (stalled) check({name, " hold"}, 32'(m_tdata), 32'(held));
      if (done) begin
        seen_done = 1'b1;
        check({name, " count at done"}, k, 32'(v.nexp));
        check({name, " valid in done"}, 32'(m_tvalid), 0);
      end else begin
        m_tready = v.stall ? c[0] : 1'b1;
        check({name, " valid"}, 32'(m_tvalid), 1);
        stalled = m_tvalid && !m_tready;
        held    = m_tdata;
        if (m_tvalid && m_tready) begin
          if (k < int'(v.nexp)) check($sformatf("%s data[%0d]", name, k), 32'(m_tdata),
                                      32'(v.exp[k]));
          else check({name, " extra sample"}, k, 32'(v.nexp));
          k++;
        end
      end
    end
    if (!seen_done) check({name, " done timeout"}, 0, 1);
    m_tready = 1'b1;
    @(negedge clk);
    check({name, " busy after"}, 32'(busy), 0);
    check({name, " done single"}, 32'(done), 0);
  endtask

  initial begin
    vec_t v;
    int   bad[2];
    #200000;
    $display("FAIL watchdog: simulation still running, expected finish");
    $fatal(1);
    bad[0] = 0;
    v = vecs[0];
  end

  initial begin
    vec_t v;
    int   bad[2];
    rst = 1'b1; start = 1'b0; stop = 1'b0; m_tready = 1'b1;
    apply_params(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    // ramp, two lines with repeat, backpressure, saturation, zero length,
    // negative slope and negative saturation under backpressure
    vecs[0] = mk(1, 0, 0, 4, 0, 32'h0001_0000, 0, 1, 0, 4);
    vecs[0].exp[0] = 16'h0000; vecs[0].exp[1] = 16'h0001;
    vecs[0].exp[2] = 16'h0002; vecs[0].exp[3] = 16'h0003;
    vecs[1] = mk(2, 32'h1000_0000, 32'h4000_0000, 2, 3, 0, 0, 2, 0, 10);
    for (int j = 0; j < 10; j++) vecs[1].exp[j] = ((j % 5) < 2) ? 16'h1000 : 16'h4000;
    vecs[2] = vecs[0];
    vecs[2].stall = 1'b1;
    vecs[3] = mk(1, 32'h7FFF_0000, 0, 3, 0, 32'h0001_0000, 0, 1, 0, 3);
    vecs[3].exp[0] = 16'h7FFF; vecs[3].exp[1] = 16'h7FFF; vecs[3].exp[2] = 16'h7FFF;
    vecs[4] = mk(1, 32'h1234_0000, 0, 0, 0, 32'h0001_0000, 0, 1, 0, 1);
    vecs[4].exp[0] = 16'h1234;
    vecs[5] = mk(1, 32'h0002_0000, 0, 4, 0, 32'hFFFF_0000, 0, 1, 0, 4);
    vecs[5].exp[0] = 16'h0002; vecs[5].exp[1] = 16'h0001;
    vecs[5].exp[2] = 16'h0000; vecs[5].exp[3] = 16'hFFFF;
    vecs[6] = mk(1, 32'h8001_0000, 0, 3, 0, 32'hFFFF_0000, 0, 1, 1, 3);
    vecs[6].exp[0] = 16'h8001; vecs[6].exp[1] = 16'h8000; vecs[6].exp[2] = 16'h8000;

    @(negedge clk);
    check("reset m_tvalid", 32'(m_tvalid), 0);
    check("reset busy", 32'(busy), 0);
    check("reset m_tdata", 32'(m_tdata), 0);
    check("reset done", 32'(done), 0);
    check("reset cfg_err", 32'(cfg_err), 0);
    rst = 1'b0;

    for (int i = 0; i < 7; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Rejected starts
    bad[0] = 0;
    bad[1] = 10;
    for (int i = 0; i < 2; i++) begin
      v   = vecs[0];
      v.n = bad[i];
      apply_params(v);
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      check($sformatf("cfg_err n=%0d", bad[i]), 32'(cfg_err), 1);
      check($sformatf("cfg busy n=%0d", bad[i]), 32'(busy), 0);
      check($sformatf("cfg valid n=%0d", bad[i]), 32'(m_tvalid), 0);
      @(negedge clk);
      check($sformatf("cfg_err pulse n=%0d", bad[i]), 32'(cfg_err), 0);
      check($sformatf("cfg busy2 n=%0d", bad[i]), 32'(busy), 0);
    end

    // Endless ramp; a start with new params mid-run must be ignored; stop while stalled
    v     = vecs[0];
    v.rep = 0;
    apply_params(v);
    @(negedge clk); start = 1'b1; m_tready = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (i > 0) @(negedge clk);
      if (i == 5) begin
        start               = 1'b1;
        params_linea[0]     = 32'h5555_0000;
        params_linet_int[0] = 32'h0003_0000;
      end
      if (i == 6) start = 1'b0;
      check($sformatf("endless data[%0d]", i), 32'(m_tdata), 32'(i % 4));
      check($sformatf("endless valid[%0d]", i), 32'(m_tvalid), 1);
    end
    @(negedge clk);
    check("pre-stop data", 32'(m_tdata), 0);
    m_tready = 1'b0;
    stop     = 1'b1;
    @(negedge clk);
    stop     = 1'b0;
    m_tready = 1'b1;
    check("stop valid", 32'(m_tvalid), 0);
    check("stop busy", 32'(busy), 0);
    check("stop no done", 32'(done), 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stop no late done", 32'(done), 0);
    end

    // Asynchronous reset mid-line, then a fresh replay from line 0
    apply_params(v);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("pre-reset data", 32'(m_tdata), 2);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("async rst valid", 32'(m_tvalid), 0);
    check("async rst busy", 32'(busy), 0);
    check("async rst data", 32'(m_tdata), 0);
    check("async rst done", 32'(done), 0);
    @(negedge clk);
    rst = 1'b0;
    v     = vecs[1];
    v.rep = 1;
    v.nexp = 5;
    run_vec(v, "post-reset");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
